// File: rtl/sar_logic_cs_param_if.sv
// Result port of the coarse/fine SAR controller: conversion result with
// valid/ready handshake plus status flags.
interface sar_logic_cs_param_if #(
  parameter int unsigned N = 10
) ();
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         eoc;
  logic         busy;
  logic         overrun;

  modport master (output dout, dout_valid, eoc, busy, overrun, input dout_ready);
  modport slave  (input dout, dout_valid, eoc, busy, overrun, output dout_ready);
endinterface

// File: rtl/sar_logic_cs_param.sv
// Parametrised coarse/fine split-array SAR controller: K coarse decisions,
// data-share into the fine array, then N-K fine decisions.
module sar_logic_cs_param #(
  parameter int unsigned N = 10,
  parameter int unsigned K = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cnvst,
  input  logic            cont,
  input  logic            cmp_out,
  input  logic            cmp_out_coarse,
  output logic            cmp_clk,
  output logic            cmp_clk_coarse,
  output logic            s_clk,
  output logic [2*N-1:0]  fine_btm,
  output logic [2*K-1:0]  coarse_btm,
  output logic            fine_switch_drain,
  output logic            coarse_switch_drain,
  output logic            s_clk_not,
  output logic [2*N-1:0]  fine_btm_not,
  output logic [2*K-1:0]  coarse_btm_not,
  output logic            fine_switch_drain_not,
  output logic            coarse_switch_drain_not,
  sar_logic_cs_param_if.master res
);

  localparam int unsigned NF = N - K;
  localparam logic [2*K-1:0] COARSE_INIT = {{K{1'b1}}, {K{1'b0}}};
  localparam logic [N-1:0]   FINE_LOW    = {{K{1'b0}}, {NF{1'b1}}};
  localparam logic [N-1:0]   MSB         = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, DRAIN1, DRAIN2, CMPC, DECC, DS1, DS2, CMPF, DECF, DONE
  } state_t;

  state_t       state;
  logic [N-1:0] sar;
  logic [N-1:0] ptr;   // one-hot pointer to the bit under decision
  logic [K-1:0] cptr;
  logic [N-1:0] top;

  assign cptr = ptr[N-1 -: K];
  assign top  = {sar[N-1 -: K], {NF{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      s_clk               <= 1'b1;
      fine_switch_drain   <= 1'b1;
      coarse_switch_drain <= 1'b1;
      fine_btm            <= '0;
      coarse_btm          <= '0;
      cmp_clk             <= 1'b0;
      cmp_clk_coarse      <= 1'b0;
      sar                 <= '0;
      ptr                 <= '0;
      res.dout            <= '0;
      res.dout_valid      <= 1'b0;
      res.eoc             <= 1'b0;
      res.busy            <= 1'b0;
      res.overrun         <= 1'b0;
    end else begin
      res.eoc <= 1'b0;
      if (res.dout_valid && res.dout_ready) res.dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          s_clk               <= ~(cnvst | cont);
          fine_switch_drain   <= 1'b1;
          coarse_switch_drain <= 1'b1;
          fine_btm            <= '0;
          coarse_btm          <= '0;
          sar                 <= MSB;
          ptr                 <= MSB;
          if (cnvst || cont) begin
            state    <= DRAIN1;
            res.busy <= 1'b1;
          end
        end
        DRAIN1: begin
          coarse_switch_drain <= 1'b0;
          state               <= DRAIN2;
        end
        DRAIN2: begin
          coarse_btm <= COARSE_INIT;
          state      <= CMPC;
        end
        CMPC: begin
          cmp_clk_coarse <= 1'b1;
          state          <= DECC;
        end
        DECC: begin
          cmp_clk_coarse <= 1'b0;
          coarse_btm <= cmp_out_coarse ? (coarse_btm | {{K{1'b0}}, cptr})
                                       : (coarse_btm & ~{cptr, {K{1'b0}}});
          sar   <= (cmp_out_coarse ? sar : (sar & ~ptr)) | (ptr >> 1);
          ptr   <= ptr >> 1;
          state <= ptr[NF] ? DS1 : CMPC;
        end
        DS1: begin
          fine_switch_drain <= 1'b0;
          state             <= DS2;
        end
        // Share coarse decisions; fine positive side starts fully set
        DS2: begin
          fine_btm <= {fine_btm[2*N-1:N] | top | FINE_LOW, fine_btm[N-1:0] | top};
          state    <= CMPF;
        end
        CMPF: begin
          cmp_clk <= 1'b1;
          state   <= DECF;
        end
        DECF: begin
          cmp_clk  <= 1'b0;
          fine_btm <= cmp_out ? (fine_btm | {{N{1'b0}}, ptr})
                              : (fine_btm & ~{ptr, {N{1'b0}}});
          sar   <= (cmp_out ? sar : (sar & ~ptr)) | (ptr >> 1);
          ptr   <= ptr >> 1;
          state <= ptr[0] ? DONE : CMPF;
        end
        // Load wins over a same-edge accept; overwrite of a pending result is flagged
        DONE: begin
          res.dout       <= sar;
          res.eoc        <= 1'b1;
          res.dout_valid <= 1'b1;
          if (res.dout_valid && !res.dout_ready) res.overrun <= 1'b1;
          s_clk               <= 1'b1;
          fine_switch_drain   <= 1'b1;
          coarse_switch_drain <= 1'b1;
          fine_btm            <= '0;
          coarse_btm          <= '0;
          cmp_clk             <= 1'b0;
          cmp_clk_coarse      <= 1'b0;
          res.busy            <= 1'b0;
          state               <= IDLE;
        end
        default: begin
          res.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign s_clk_not               = ~s_clk;
  assign fine_btm_not            = ~fine_btm;
  assign coarse_btm_not          = ~coarse_btm;
  assign fine_switch_drain_not   = ~fine_switch_drain;
  assign coarse_switch_drain_not = ~coarse_switch_drain;

endmodule

// File: tb/tb_sar_logic_cs_param.sv
// Bench for sar_logic_cs_param: ideal comparator model driven by a target
// code, results checked against the target-derived expectations.
module tb_sar_logic_cs_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // ---------------- DUT 0 : N=10, K=6 ----------------
  logic        cnvst0, cont0, co0, coc0, cc0, ccc0, s0, fsd0, csd0;
  logic        s0n, fsd0n, csd0n;
  logic [19:0] fb0, fb0n;
  logic [11:0] cb0, cb0n;
  logic [9:0]  tgt0;
  logic [1:0]  cmode0;
  int          d0;
  logic        mb0;

  sar_logic_cs_param_if #(.N(10)) r0 ();

  sar_logic_cs_param #(.N(10), .K(6)) u0 (
    .clk(clk), .rst_n(rst_n), .cnvst(cnvst0), .cont(cont0),
    .cmp_out(co0), .cmp_out_coarse(coc0), .cmp_clk(cc0), .cmp_clk_coarse(ccc0),
    .s_clk(s0), .fine_btm(fb0), .coarse_btm(cb0),
    .fine_switch_drain(fsd0), .coarse_switch_drain(csd0),
    .s_clk_not(s0n), .fine_btm_not(fb0n), .coarse_btm_not(cb0n),
    .fine_switch_drain_not(fsd0n), .coarse_switch_drain_not(csd0n),
    .res(r0)
  );

  // ---------------- DUT 1 : N=12, K=4 ----------------
  logic        cnvst1, cont1, co1, coc1, cc1, ccc1, s1, fsd1, csd1;
  logic        s1n, fsd1n, csd1n;
  logic [23:0] fb1, fb1n;
  logic [7:0]  cb1, cb1n;
  logic [11:0] tgt1;
  int          d1;
  logic        mb1;

  sar_logic_cs_param_if #(.N(12)) r1 ();

  sar_logic_cs_param #(.N(12), .K(4)) u1 (
    .clk(clk), .rst_n(rst_n), .cnvst(cnvst1), .cont(cont1),
    .cmp_out(co1), .cmp_out_coarse(coc1), .cmp_clk(cc1), .cmp_clk_coarse(ccc1),
    .s_clk(s1), .fine_btm(fb1), .coarse_btm(cb1),
    .fine_switch_drain(fsd1), .coarse_switch_drain(csd1),
    .s_clk_not(s1n), .fine_btm_not(fb1n), .coarse_btm_not(cb1n),
    .fine_switch_drain_not(fsd1n), .coarse_switch_drain_not(csd1n),
    .res(r1)
  );

  // Ideal comparator: the d-th decision of a conversion returns target bit N-1-d
  always @(posedge clk) begin
    if (!rst_n || s0) d0 <= 0;
    else if (cc0 || ccc0) d0 <= d0 + 1;
    if (!rst_n || s1) d1 <= 0;
    else if (cc1 || ccc1) d1 <= d1 + 1;
  end
  assign mb0  = (d0 < 10) && tgt0[4'(9 - d0)];
  assign mb1  = (d1 < 12) && tgt1[4'(11 - d1)];
  assign co0  = (cmode0 == 2'd2) ? mb0 : cmode0[0];
  assign coc0 = co0;
  assign co1  = mb1;
  assign coc1 = mb1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic start0(input logic [9:0] t);
    tgt0   = t;
    cnvst0 = 1'b1;
    tick(1);
    cnvst0 = 1'b0;
  endtask

  // Full conversion on DUT 0 with milestone checks (edge 0 = cnvst sample)
  task automatic conv0(input logic [9:0] t);
    logic [63:0] top, ce, de;
    top = 64'(t >> 4);
    ce  = (top << 6) | top;
    de  = (((top << 4) | 64'hF) << 10) | (top << 4);
    start0(t);
    check("busy_start", 64'(r0.busy), 64'd1);
    tick(14);
    check("coarse_btm", 64'(cb0), ce);
    tick(2);
    check("ds2_fine_btm", 64'(fb0), de);
    tick(8);
    check("done_fine_btm", 64'(fb0), {44'd0, t, t});
    check("pre_done_flags", 64'({r0.busy, r0.eoc, r0.dout_valid}), 64'b100);
    tick(1);
    check("dout", 64'(r0.dout), 64'(t));
    check("done_flags", 64'({r0.busy, r0.eoc, r0.dout_valid, s0}), 64'b0111);
    tick(1);
    check("accepted", 64'({r0.eoc, r0.dout_valid}), 64'b00);
  endtask

  task automatic conv1(input logic [11:0] t);
    int lat;
    tgt1   = t;
    cnvst1 = 1'b1;
    tick(1);
    cnvst1 = 1'b0;
    lat = 0;
    while (!r1.eoc && lat < 200) begin
      tick(1);
      lat++;
    end
    check("lat1", 64'(lat), 64'd29);
    check("dout1", 64'(r1.dout), 64'(t));
    check("done1_state", 64'({r1.dout_valid, r1.busy, s1, fb1}), {37'd0, 3'b101, 24'd0});
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] t1, t2;
    int seen;
    cmode0 = 2'd2; tgt0 = '0; tgt1 = '0;
    // Reset with random inputs
    rst_n  = 1'b0;
    cnvst0 = 1'($urandom); cont0 = 1'($urandom); cnvst1 = 1'($urandom); cont1 = 1'($urandom);
    r0.dout_ready = 1'($urandom); r1.dout_ready = 1'($urandom);
    tick(2);
    check("rst_ctl0", 64'({s0, fsd0, csd0, cc0, ccc0}), 64'b11100);
    check("rst_arrays0", 64'({fb0, cb0}), 64'd0);
    check("rst_res0", 64'({r0.dout, r0.dout_valid, r0.eoc, r0.busy, r0.overrun}), 64'd0);
    check("rst_not0", 64'({s0n, fsd0n, csd0n, fb0n, cb0n}), {29'd0, 3'b000, 20'hFFFFF, 12'hFFF});
    check("rst_all1", 64'({s1, fsd1, csd1, cc1, ccc1, fb1, cb1, r1.dout_valid, r1.busy}), 64'b11100 << 34);
    check("rst_not1", 64'({s1n, fsd1n, csd1n, fb1n, cb1n}), {29'd0, 3'b000, 24'hFFFFFF, 8'hFF});

    cnvst0 = 0; cont0 = 0; cnvst1 = 0; cont1 = 0;
    r0.dout_ready = 1'b1; r1.dout_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);

    // Comparators stuck high, stuck low, then a fixed target
    cmode0 = 2'd1; conv0(10'h3FF);
    cmode0 = 2'd0; conv0(10'h000);
    cmode0 = 2'd2; conv0(10'h2A5);
    for (int i = 0; i < 5; i++) conv0(10'($urandom_range(0, 1023)));

    // Continuous mode, result never accepted -> overrun
    t1 = 10'($urandom); t2 = 10'($urandom);
    do_reset();
    r0.dout_ready = 1'b0; tgt0 = t1; cont0 = 1'b1;
    tick(1);
    tick(25);
    check("cont_r1", 64'({r0.dout, r0.dout_valid, r0.overrun, r0.busy}), 64'({t1, 3'b100}));
    tgt0 = t2;
    tick(1);
    check("cont_restart", 64'(r0.busy), 64'd1);
    cont0 = 1'b0;
    tick(25);
    check("cont_r2_ovr", 64'({r0.dout, r0.dout_valid, r0.overrun, r0.eoc}), 64'({t2, 3'b111}));
    tick(2);
    check("cont_dropped_idle", 64'({r0.busy, s0}), 64'b01);

    // Continuous mode with consumer always ready
    do_reset();
    r0.dout_ready = 1'b1; tgt0 = t1; cont0 = 1'b1;
    tick(1);
    tick(25);
    check("rdy_r1", 64'({r0.dout, r0.dout_valid, r0.eoc}), 64'({t1, 2'b11}));
    tgt0 = t2;
    tick(1);
    check("rdy_pulse", 64'({r0.dout_valid, r0.busy}), 64'b01);
    cont0 = 1'b0;
    tick(25);
    check("rdy_r2", 64'({r0.dout, r0.dout_valid, r0.overrun}), 64'({t2, 2'b10}));
    tick(1);
    check("rdy_r2_pulse", 64'(r0.dout_valid), 64'd0);

    // Accept on the same edge as the second load: load wins, no overrun
    r0.dout_ready = 1'b0; tgt0 = t1; cont0 = 1'b1;
    tick(1);
    tick(25);
    tgt0 = t2;
    tick(1);
    cont0 = 1'b0;
    tick(24);
    r0.dout_ready = 1'b1;
    tick(1);
    check("coinc_load", 64'({r0.dout, r0.dout_valid, r0.overrun, r0.eoc}), 64'({t2, 3'b101}));
    tick(1);
    check("coinc_after", 64'(r0.dout_valid), 64'd0);

    // Reset during a fine decision aborts the conversion
    start0(10'($urandom));
    tick(17);
    check("in_decf", 64'(cc0), 64'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("abort_state", 64'({s0, fsd0, csd0, cc0, r0.busy, r0.eoc, r0.dout_valid}), 64'b1110000);
    check("abort_arrays", 64'({fb0, cb0, r0.dout}), 64'd0);
    seen = 0;
    repeat (30) begin
      tick(1);
      if (r0.eoc || r0.busy) seen++;
    end
    check("no_result_after_abort", 64'(seen), 64'd0);
    conv0(10'($urandom));

    // N=12, K=4 instance
    conv1(12'hA5C);
    for (int i = 0; i < 3; i++) conv1(12'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sar_logic_cs_param.md
Name: sar_logic_cs_param

Overview:
- Parametrised coarse/fine SAR controller for the split-array ADC, with N-bit resolution and K coarse decision cycles.
- Sequence per conversion:
  - Sample.
  - Drain the coarse array and resolve the top K bits on the coarse comparator.
  - Data-share the coarse decisions into the fine array.
  - Resolve the remaining N-K bits on the fine comparator.
- Adds three things the fixed 10-bit/k6 controller lacks: a valid/ready result port, continuous (free-running) mode, and a sticky overrun flag.
- Sits between the analog front end (comparators, bootstrap switch, DAC bottom plates) and the digital back end.

Parameters:
N, 10, resolution in bits (N >= 3)
K, 6, number of coarse cycles (1 <= K <= N-1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cnvst  in  1  start conversion (sampled in IDLE only)
cont  in  1  continuous mode: 1 restarts a conversion from IDLE without cnvst
cmp_out  in  1  fine comparator decision (1 = keep bit)
cmp_out_coarse  in  1  coarse comparator decision
cmp_clk  out  1  fine comparator clock
cmp_clk_coarse  out  1  coarse comparator clock
s_clk  out  1  bootstrap sampling switch (1 = track)
fine_btm  out  2N  fine bottom plates; [i] = negative-side cap of bit i, [N+i] = positive-side cap of bit i
coarse_btm  out  2K  coarse bottom plates; [j] / [K+j] map to sar bit N-K+j
fine_switch_drain  out  1  fine array drain switch
coarse_switch_drain  out  1  coarse array drain switch
s_clk_not, fine_btm_not, coarse_btm_not, fine_switch_drain_not, coarse_switch_drain_not  out  (matching widths)  bitwise inverses of the signals above, combinational
dout  out  N  last completed conversion result
dout_valid  out  1  dout holds an unconsumed result
dout_ready  in  1  consumer accepts dout
eoc  out  1  one-cycle pulse when dout is updated
busy  out  1  state != IDLE
overrun  out  1  sticky: a result was overwritten before it was accepted

Behaviour:
- All outputs are registered except the *_not outputs.
- Reset (rst_n=0 at clk edge) values:
  - state = IDLE.
  - s_clk=1; fine_switch_drain=1; coarse_switch_drain=1.
  - fine_btm=0; coarse_btm=0; cmp_clk=0; cmp_clk_coarse=0.
  - Internal sar=0; dout=0; dout_valid=0; eoc=0; busy=0; overrun=0.
- Reset mid-conversion aborts immediately; no result is produced.
- States: IDLE, DRAIN1, DRAIN2, CMPC, DECC, DS1, DS2, CMPF, DECF, DONE.
- IDLE:
  - s_clk=1, both drains=1, both btm arrays=0.
  - sar <= 1 followed by N-1 zeros (MSB set).
  - If cnvst|cont then go to DRAIN1 and s_clk<=0 at that edge.
  - cnvst is ignored outside IDLE.
- DRAIN1: coarse_switch_drain<=0; go to DRAIN2.
- DRAIN2: coarse_btm <= K ones followed by K zeros; j=K-1; go to CMPC.
- CMPC: cmp_clk_coarse<=1; go to DECC. The comparator clock is high for exactly the DECC cycle, and DECC samples cmp_out_coarse at the end of that cycle.
- DECC, with b = N-K+j:
  - If cmp_out_coarse=1: coarse_btm[j]<=1.
  - If cmp_out_coarse=0: coarse_btm[K+j]<=0 and sar[b]<=0.
  - sar[b-1]<=1.
  - If j>0: j<=j-1, go to CMPC. Otherwise go to DS1.
- DS1: fine_switch_drain<=0; go to DS2.
- DS2:
  - For each i in N-K..N-1 with sar[i]=1: fine_btm[i]<=1 and fine_btm[N+i]<=1.
  - fine_btm[N+N-K-1:N] <= all ones.
  - b=N-K-1; go to CMPF.
- CMPF: cmp_clk<=1 for the DECF cycle; go to DECF.
- DECF:
  - If cmp_out=1: fine_btm[b]<=1.
  - If cmp_out=0: fine_btm[N+b]<=0 and sar[b]<=0.
  - If b>0: sar[b-1]<=1, b<=b-1, go to CMPF. Otherwise go to DONE.
- DONE:
  - dout<=sar; eoc<=1 for one cycle; dout_valid<=1.
  - Arrays and drains return to reset values; s_clk<=1; go to IDLE.
- Handshake:
  - dout_valid clears on the edge where dout_valid=1 and dout_ready=1.
  - If a DONE load coincides with an accept: the load wins, dout_valid stays 1, overrun unchanged.
  - If a DONE load happens with dout_valid=1 and dout_ready=0: dout is overwritten and overrun<=1.
  - overrun clears only on reset.
- Latency and throughput:
  - dout_valid/eoc assert 2N+5 edges after the edge that samples cnvst.
  - Continuous-mode period is 2N+6 cycles; IDLE/track lasts exactly 1 cycle when cont=1.
- Dropping cont mid-conversion finishes the current conversion, then waits in IDLE for cnvst.

Test Plan:
1. Hold rst_n=0 for 2 edges with random inputs -> every output at its reset value; *_not outputs are exact inverses.
2. N=10,K=6, cmp_out=cmp_out_coarse=1, one cnvst pulse -> coarse_btm=0xFFF after coarse phase, fine_btm=0xFFFFF at DONE, dout=0x3FF, eoc and dout_valid rise 25 edges after cnvst, busy high for 25 cycles.
3. Both comparators held at 0 -> coarse_btm=0x000, fine_btm=0x00000 at DONE, dout=0x000.
4. Comparator model returns bit b of target 0x2A5 at each decision -> dout=0x2A5; at DS2 fine_btm[19:14] and [9:4] equal sar[9:4]=101010 replicated; fine_btm[13:10]=1111.
5. cont=1, dout_ready=0 -> first result at edge 25, second at edge 51 sets overrun=1 with dout = second result. Repeat with dout_ready=1 -> overrun stays 0 and dout_valid pulses one cycle per result.
6. rst_n=0 during DECF, then cnvst -> outputs at reset values one edge later, no eoc. Re-run with N=12,K=4, target 0xA5C -> dout=0xA5C, latency 29 edges.
